// File: rtl/eco32f_issue_queue.sv
// Fetch-to-decode issue queue: a DEPTH-entry FIFO of fetched instructions whose
// head is released to decode only once a per-register countdown scoreboard is clear.
module eco32f_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_insn,
  input  logic                       if_exc_ibus_fault,
  input  logic                       id_stall,
  input  logic                       id_flush,
  output logic                       id_valid,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_insn,
  output logic                       id_exc_ibus_fault,
  output logic                       id_bubble,
  output logic [$clog2(DEPTH+1)-1:0] id_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNTW   = $clog2(DEPTH + 1);
  localparam int MAXLAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);

  localparam logic [CW-1:0] LOAD_LAT_C = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MUL_LAT_C  = CW'(MUL_LAT);

  localparam logic [5:0] ECO32F_OP_MUL   = 6'h04;
  localparam logic [5:0] ECO32F_OP_MULI  = 6'h05;
  localparam logic [5:0] ECO32F_OP_MULU  = 6'h06;
  localparam logic [5:0] ECO32F_OP_MULUI = 6'h07;
  localparam logic [5:0] ECO32F_OP_SAR   = 6'h1C;
  localparam logic [5:0] ECO32F_OP_JAL   = 6'h2C;
  localparam logic [5:0] ECO32F_OP_JALR  = 6'h2D;
  localparam logic [5:0] ECO32F_OP_RFX   = 6'h2F;
  localparam logic [5:0] ECO32F_OP_LDW   = 6'h30;
  localparam logic [5:0] ECO32F_OP_LDH   = 6'h31;
  localparam logic [5:0] ECO32F_OP_LDHU  = 6'h32;
  localparam logic [5:0] ECO32F_OP_LDB   = 6'h33;
  localparam logic [5:0] ECO32F_OP_LDBU  = 6'h34;

  // Handshake: a fetch transfer occurs on if_valid & if_ready (dropped under
  // id_flush); an issue occurs on id_valid & !id_stall & !id_flush.

  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     pc_mem_d   [DEPTH];
  logic [31:0]     insn_mem_q [DEPTH];
  logic [31:0]     insn_mem_d [DEPTH];
  logic [DEPTH-1:0] fault_mem_q, fault_mem_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   cnt_q [32];
  logic [CW-1:0]   cnt_d [32];

  logic       head_present, hazard, push, pop;
  logic       is_load, is_mul;
  logic [5:0] head_op;
  logic [4:0] src_x, src_y, dst;

  assign id_pc             = pc_mem_q[rd_ptr_q];
  assign id_insn           = insn_mem_q[rd_ptr_q];
  assign id_exc_ibus_fault = fault_mem_q[rd_ptr_q];
  assign id_count          = count_q;

  assign head_op      = id_insn[31:26];
  assign head_present = (count_q != '0);
  assign if_ready     = (count_q != CNTW'(DEPTH));

  always_comb begin
    src_x = (head_op == ECO32F_OP_RFX) ? 5'd30 : id_insn[25:21];
    src_y = id_insn[20:16];
    if (head_op <= ECO32F_OP_SAR && !head_op[0]) begin
      dst = id_insn[15:11];
    end else if (head_op == ECO32F_OP_JAL || head_op == ECO32F_OP_JALR) begin
      dst = 5'd31;
    end else begin
      dst = id_insn[20:16];
    end
    is_load = (head_op == ECO32F_OP_LDW) || (head_op == ECO32F_OP_LDH) ||
              (head_op == ECO32F_OP_LDHU) || (head_op == ECO32F_OP_LDB) ||
              (head_op == ECO32F_OP_LDBU);
    is_mul  = (head_op == ECO32F_OP_MUL) || (head_op == ECO32F_OP_MULI) ||
              (head_op == ECO32F_OP_MULU) || (head_op == ECO32F_OP_MULUI);
  end

  // Entry 0 of the scoreboard is pinned to zero, so r0 never blocks.
  assign hazard    = head_present & ((cnt_q[src_x] != '0) | (cnt_q[src_y] != '0));
  assign id_valid  = head_present & ~hazard;
  assign id_bubble = head_present & hazard;

  assign push = if_valid & if_ready & ~id_flush;
  assign pop  = id_valid & ~id_stall & ~id_flush;

  always_comb begin
    pc_mem_d    = pc_mem_q;
    insn_mem_d  = insn_mem_q;
    fault_mem_d = fault_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = if_pc;
      insn_mem_d[wr_ptr_q]  = if_insn;
      fault_mem_d[wr_ptr_q] = if_exc_ibus_fault;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (id_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Counters only age when the downstream pipeline advances; an issuing
  // tracked write reloads its entry, overriding that cycle's decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (!id_stall) begin
      for (int i = 1; i < 32; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (pop && dst != 5'd0) begin
        if (is_load && LOAD_LAT != 0) begin
          cnt_d[dst] = LOAD_LAT_C;
        end else if (is_mul && MUL_LAT != 0) begin
          cnt_d[dst] = MUL_LAT_C;
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        insn_mem_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      fault_mem_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pc_mem_q    <= pc_mem_d;
      insn_mem_q  <= insn_mem_d;
      fault_mem_q <= fault_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_eco32f_issue_queue.sv
// Bench for eco32f_issue_queue: directed scenarios plus randomized traffic checked
// against a queue-based model that tracks register readiness in advancing-cycle time.
module tb_eco32f_issue_queue;

  localparam int DEPTH    = 4;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 2;
  localparam int CNTW     = $clog2(DEPTH + 1);

  logic            clk, rst;
  logic            if_valid, if_ready, if_exc_ibus_fault;
  logic [31:0]     if_pc, if_insn;
  logic            id_stall, id_flush;
  logic            id_valid, id_exc_ibus_fault, id_bubble;
  logic [31:0]     id_pc, id_insn;
  logic [CNTW-1:0] id_count;

  int checks = 0;
  int errors = 0;

  eco32f_issue_queue #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn),
    .if_exc_ibus_fault(if_exc_ibus_fault),
    .id_stall(id_stall), .id_flush(id_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
    .id_exc_ibus_fault(id_exc_ibus_fault), .id_bubble(id_bubble), .id_count(id_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        f;
  } ent_t;

  ent_t mq[$];
  int   reg_ready[32];  // advancing-cycle index at which each register is readable
  int   adv;            // number of non-stalled cycles elapsed
  bit   m_push, m_pop;
  logic [31:0] exp_q[$];

  function automatic int m_lat(logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op >= 6'h30 && op <= 6'h34) return LOAD_LAT;
    if (op >= 6'h04 && op <= 6'h07) return MUL_LAT;
    return 0;
  endfunction

  function automatic int m_rd(logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op <= 6'h1C && op[0] == 1'b0) return int'(i[15:11]);
    if (op == 6'h2C || op == 6'h2D) return 31;
    return int'(i[20:16]);
  endfunction

  function automatic bit m_busy(int r);
    return (r != 0) && (reg_ready[r] > adv);
  endfunction

  function automatic bit m_hazard();
    logic [31:0] i;
    int x;
    if (mq.size() == 0) return 1'b0;
    i = mq[0].insn;
    x = (i[31:26] == 6'h2F) ? 30 : int'(i[25:21]);
    return m_busy(x) || m_busy(int'(i[20:16]));
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && !m_hazard();
  endfunction

  function automatic bit m_bubble();
    return (mq.size() > 0) && m_hazard();
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) reg_ready[r] = 0;
    adv = 0;
  endtask

  task automatic model_tick(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                            input logic f, input logic s, input logic fl);
    ent_t e;
    int lat, rd;
    m_pop  = m_valid() && !s && !fl;
    m_push = v && (mq.size() < DEPTH) && !fl;
    if (m_pop) begin
      lat = m_lat(mq[0].insn);
      rd  = m_rd(mq[0].insn);
      if (lat > 0 && rd != 0) reg_ready[rd] = adv + 1 + lat;
    end
    if (!s) adv++;
    if (fl) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.pc = pc; e.insn = insn; e.f = f;
        mq.push_back(e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic f, input logic s, input logic fl);
    if_valid = v; if_pc = pc; if_insn = insn; if_exc_ibus_fault = f;
    id_stall = s; id_flush = fl;
    model_tick(v, pc, insn, f, s, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rrr(logic [5:0] op, logic [4:0] rd, logic [4:0] a, logic [4:0] b);
    return {op, a, b, rd, 11'h0};
  endfunction

  function automatic logic [31:0] rri(logic [5:0] op, logic [4:0] rd, logic [4:0] a);
    return {op, a, rd, 16'h0040};
  endfunction

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 5);
    if (r == 4) return 5'd30;
    if (r == 5) return 5'd31;
    return 5'(r);
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h30, 6'h32, 6'h34, 6'h2C, 6'h2F, 6'h35};
    op = ops[$urandom_range(0, 11)];
    return {op, pick_reg(), pick_reg(), pick_reg(), 11'($urandom)};
  endfunction

  // Push two instructions back to back, then idle; report non-stalled bubble
  // cycles and the cycle indices at which each was seen issuing.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] stall_mask,
                          output int bubbles, output int iss0, output int iss1);
    int n;
    logic s;
    bubbles = 0; iss0 = -1; iss1 = -1; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      s = stall_mask[c];
      if (id_bubble && !s) bubbles++;
      if (id_valid && !s) begin
        if (n == 0) iss0 = c; else iss1 = c;
        n++;
      end
      cycle(c < 2, 32'h100 + 32'(4 * c), (c == 0) ? a : b, 1'b0, s, 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_insn = '0; if_exc_ibus_fault = 1'b0;
    id_stall = 1'b0; id_flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    checks++; if (id_bubble !== 1'b0) begin errors++; $display("FAIL reset_id_bubble got %b want 0", id_bubble); end
    checks++; if (id_count !== '0) begin errors++; $display("FAIL reset_id_count got %0d want 0", id_count); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int k;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 32'h2000 + 32'(4 * k), 32'h0, k[0], 1'b1, 1'b0);
      if (m_push) k++;
    end
    checks++; if (id_count !== CNTW'(4)) begin errors++; $display("FAIL fill_count got %0d want 4", id_count); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fill_if_ready got %b want 0", if_ready); end
    checks++; if (k != 4) begin errors++; $display("FAIL fill_accepted got %0d want 4", k); end
    // Pop while full: the 5th offer is still refused this cycle.
    cycle(1'b1, 32'h2000 + 32'(4 * k), 32'h0, k[0], 1'b0, 1'b0);
    if (m_push) k++;
    checks++; if (id_count !== CNTW'(3)) begin errors++; $display("FAIL fill_pop_count got %0d want 3", id_count); end
    checks++; if (id_pc !== 32'h2004) begin errors++; $display("FAIL fill_head_pc got %h want 00002004", id_pc); end
    cycle(1'b1, 32'h2000 + 32'(4 * k), 32'h0, k[0], 1'b1, 1'b0);
    if (m_push) k++;
    checks++; if (id_count !== CNTW'(4) || k != 5) begin
      errors++; $display("FAIL fill_fifth count %0d accepted %0d want 4/5", id_count, k);
    end
    drain();
  endtask

  task automatic test_load_use();
    int bub, i0, i1;
    run_pair(rri(6'h30, 5'd5, 5'd1), rrr(6'h00, 5'd6, 5'd5, 5'd7), 32'h0, bub, i0, i1);
    checks++; if (bub != LOAD_LAT) begin errors++; $display("FAIL load_use_bubbles got %0d want %0d", bub, LOAD_LAT); end
    checks++; if (i1 - i0 != LOAD_LAT + 1 || i0 < 0) begin
      errors++; $display("FAIL load_use_gap got %0d want %0d", i1 - i0, LOAD_LAT + 1);
    end
    drain();
  endtask

  task automatic test_mul_use();
    int bub, i0, i1;
    run_pair(rrr(6'h04, 5'd3, 5'd1, 5'd2), rrr(6'h00, 5'd4, 5'd3, 5'd3), 32'h0, bub, i0, i1);
    checks++; if (bub != MUL_LAT) begin errors++; $display("FAIL mul_use_bubbles got %0d want %0d", bub, MUL_LAT); end
    checks++; if (i1 - i0 != MUL_LAT + 1 || i0 < 0) begin
      errors++; $display("FAIL mul_use_gap got %0d want %0d", i1 - i0, MUL_LAT + 1);
    end
    drain();
    run_pair(rrr(6'h04, 5'd3, 5'd1, 5'd2), rrr(6'h00, 5'd4, 5'd3, 5'd3), 32'b11100, bub, i0, i1);
    checks++; if (bub != MUL_LAT || i1 < 0) begin
      errors++; $display("FAIL mul_stall_bubbles got %0d want %0d", bub, MUL_LAT);
    end
    checks++; if (i1 - i0 != MUL_LAT + 4) begin
      errors++; $display("FAIL mul_stall_gap got %0d want %0d", i1 - i0, MUL_LAT + 4);
    end
    drain();
  endtask

  task automatic test_r0();
    int bub, i0, i1;
    run_pair(rri(6'h30, 5'd0, 5'd2), rrr(6'h00, 5'd1, 5'd0, 5'd0), 32'h0, bub, i0, i1);
    checks++; if (bub != 0) begin errors++; $display("FAIL r0_bubbles got %0d want 0", bub); end
    checks++; if (i1 - i0 != 1 || i0 < 0) begin errors++; $display("FAIL r0_gap got %0d want 1", i1 - i0); end
    drain();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) cycle(1'b1, 32'h3000 + 32'(4 * c), 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (id_count !== CNTW'(3)) begin errors++; $display("FAIL flush_pre_count got %0d want 3", id_count); end
    cycle(1'b1, 32'h300C, 32'h0, 1'b0, 1'b1, 1'b1);
    checks++; if (id_count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", id_count); end
    checks++; if (id_valid !== 1'b0 || id_bubble !== 1'b0) begin
      errors++; $display("FAIL flush_head valid %b bubble %b want 0/0", id_valid, id_bubble);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (id_count !== '0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop count %0d valid %b want 0/0", id_count, id_valid);
    end
    drain();
  endtask

  task automatic test_wrap();
    int pushed, issued, cyc;
    logic s;
    logic [31:0] exp_pc;
    pushed = 0; issued = 0; cyc = 0;
    exp_q.delete();
    while ((pushed < 2 * DEPTH + 3 || issued < 2 * DEPTH + 3) && cyc < 300) begin
      s = ($urandom_range(0, 2) == 0);
      checks++; if (id_valid !== m_valid() || id_count !== CNTW'(mq.size())) begin
        errors++; $display("FAIL wrap_state valid %b count %0d want %b/%0d", id_valid, id_count, m_valid(), mq.size());
      end
      if (id_valid && !s) begin
        exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL wrap_order got %h want %h", id_pc, exp_pc); end
        issued++;
      end
      cycle(pushed < 2 * DEPTH + 3, 32'h4000 + 32'(4 * pushed), rand_insn(), 1'b0, s, 1'b0);
      if (m_push) begin
        exp_q.push_back(32'h4000 + 32'(4 * pushed));
        pushed++;
      end
      cyc++;
    end
    checks++; if (issued != 2 * DEPTH + 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_total issued %0d left %0d want %0d/0", issued, exp_q.size(), 2 * DEPTH + 3);
    end
    drain();
  endtask

  task automatic test_random();
    logic v, s, fl;
    for (int c = 0; c < 400; c++) begin
      checks++; if (id_count !== CNTW'(mq.size()) || if_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rand_count got %0d/%b want %0d", id_count, if_ready, mq.size());
      end
      checks++; if (id_valid !== m_valid() || id_bubble !== m_bubble()) begin
        errors++; $display("FAIL rand_head valid %b bubble %b want %b/%b", id_valid, id_bubble, m_valid(), m_bubble());
      end
      if (mq.size() > 0) begin
        checks++; if (id_pc !== mq[0].pc || id_insn !== mq[0].insn || id_exc_ibus_fault !== mq[0].f) begin
          errors++; $display("FAIL rand_data got %h %h %b want %h %h %b",
                             id_pc, id_insn, id_exc_ibus_fault, mq[0].pc, mq[0].insn, mq[0].f);
        end
      end
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 39) == 0);
      cycle(v, $urandom, rand_insn(), 1'($urandom_range(0, 1)), s, fl);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'h5000, rrr(6'h04, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5004, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h5008, 32'h0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (id_count !== '0 || if_ready !== 1'b1 || id_valid !== 1'b0) begin
      errors++; $display("FAIL midreset count %0d ready %b valid %b want 0/1/0", id_count, if_ready, id_valid);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 32'h6000, rrr(6'h00, 5'd4, 5'd3, 5'd3), 1'b0, 1'b1, 1'b0);
    checks++; if (id_valid !== 1'b1 || id_bubble !== 1'b0) begin
      errors++; $display("FAIL midreset_sb valid %b bubble %b want 1/0", id_valid, id_bubble);
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_load_use();
    test_mul_use();
    test_r0();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
